// File: rtl/dac_ctrl_pkg.sv
// Shared timing constants and types for the Digilent-style two-channel DAC controller.
// Optional feature: define DAC_CTRL_SIGNED_EN to convert two's complement samples to offset binary.
package dac_ctrl_pkg;

  localparam int CNT_W     = 10;
  localparam int FRAME_LEN = 1024;
  localparam int BIT_CLKS  = 16;
  localparam int NUM_BITS  = 32;
  localparam int LD_START  = 520;
  localparam int LD_LEN    = 16;
  localparam int SAMPLE_W  = 16;
  localparam int BIT_W     = $clog2(BIT_CLKS);

  typedef logic [CNT_W-1:0]    cnt_t;
  typedef logic [SAMPLE_W-1:0] sample_t;

  localparam cnt_t CNT_LAST = cnt_t'(FRAME_LEN - 1);
  localparam cnt_t BIT_END  = cnt_t'(BIT_CLKS * NUM_BITS);
  localparam cnt_t LD_FIRST = cnt_t'(LD_START);
  localparam cnt_t LD_END   = cnt_t'(LD_START + LD_LEN);

  // Enables decoded by the timer; sck/ld/next/bit_phase describe the upcoming count.
  typedef struct packed {
    logic load;
    logic shift;
    logic bit_phase;
    logic sck;
    logic ld;
    logic next;
  } timer_dec_t;

  function automatic sample_t to_dac_code(input sample_t s);
`ifdef DAC_CTRL_SIGNED_EN
    return s ^ sample_t'(16'h8000);
`else
    return s;
`endif
  endfunction

endpackage

// File: rtl/dac_ctrl_timer.sv
// Free-running 1024-clock frame counter and decode of the per-frame enables.
// Output-related enables are decoded from the next count so the top-level flops line up with cnt.
module dac_ctrl_timer
  import dac_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  output timer_dec_t dec
);

  cnt_t cnt;
  cnt_t cnt_nxt;

  assign cnt_nxt = cnt + cnt_t'(1);

  // Resetting to the last count makes the first edge after reset a load edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt <= CNT_LAST;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every flop sees pre-edge values.
      cnt <= cnt_nxt;
    end
  end

  always_comb begin
    // NOTE: default every field first so no path leaves a value unassigned (no latch).
    dec           = '0;
    dec.load      = (cnt == CNT_LAST);
    dec.shift     = (cnt[BIT_W-1:0] == '1) && (cnt < BIT_END);
    dec.bit_phase = (cnt_nxt < BIT_END);
    dec.sck       = dec.bit_phase && cnt_nxt[BIT_W-1];
    dec.ld        = (cnt_nxt >= LD_FIRST) && (cnt_nxt < LD_END);
    dec.next      = (cnt_nxt == '0);
  end

endmodule

// File: rtl/dac_digilent_ctrl.sv
// Serial controller for a two-channel 16-bit DAC: one L/R pair per 1024-clock frame, MSB first.
// Define DAC_CTRL_SIGNED_EN to invert sample bit 15 at load (two's complement to offset binary).
module dac_digilent_ctrl
  import dac_ctrl_pkg::*;
(
  input  logic                clk,
  input  logic                reset,
  input  logic [SAMPLE_W-1:0] sample_l,
  input  logic [SAMPLE_W-1:0] sample_r,
  output logic                next,
  output logic                sck,
  output logic                sdi,
  output logic                ld
);

  timer_dec_t dec;
  logic [NUM_BITS-1:0] sh;
  logic [NUM_BITS-1:0] sh_nxt;

  dac_ctrl_timer u_timer (
    .clk   (clk),
    .reset (reset),
    .dec   (dec)
  );

  always_comb begin
    sh_nxt = sh;
    if (dec.load) begin
      sh_nxt = {to_dac_code(sample_l), to_dac_code(sample_r)};
    end else if (dec.shift) begin
      sh_nxt = {sh[NUM_BITS-2:0], 1'b0};
    end
  end

  // sdi is taken from sh_nxt so the freshly loaded MSB is on the line in the cycle after load.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sh   <= '0;
      sdi  <= 1'b0;
      sck  <= 1'b0;
      ld   <= 1'b0;
      next <= 1'b0;
    end else begin
      sh   <= sh_nxt;
      sdi  <= dec.bit_phase && sh_nxt[NUM_BITS-1];
      sck  <= dec.sck;
      ld   <= dec.ld;
      next <= dec.next;
    end
  end

endmodule

// File: tb/tb_dac_digilent_ctrl.sv
// Directed bench for dac_digilent_ctrl: frame timing, serial word, sample handoff and mid-frame reset.
module tb_dac_digilent_ctrl;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] sample_l = 16'h0FF0;
  logic [15:0] sample_r = 16'hAA55;
  logic        next, sck, sdi, ld;

  int vectors = 0;
  int miscompares = 0;

  always #10 clk = ~clk;

  dac_digilent_ctrl dut (
    .clk      (clk),
    .reset    (reset),
    .sample_l (sample_l),
    .sample_r (sample_r),
    .next     (next),
    .sck      (sck),
    .sdi      (sdi),
    .ld       (ld)
  );

  function automatic logic [31:0] dac_word(input logic [15:0] l, input logic [15:0] r);
`ifdef DAC_CTRL_SIGNED_EN
    return {l ^ 16'h8000, r ^ 16'h8000};
`else
    return {l, r};
`endif
  endfunction

  // Captures one frame starting the cycle after its load edge; at cycle chg_k new samples are driven.
  task automatic check_frame(input string name, input logic [31:0] exp_word, input int chg_k,
                             input logic [15:0] nl, input logic [15:0] nr);
    logic [31:0] word;
    logic        prev_sck, exp_sck, exp_ld, exp_next;
    int rises, rises_in_ld, sck_err, ld_err, next_err, idle_err, sdi_err;
    word = '0; prev_sck = 1'b0;
    rises = 0; rises_in_ld = 0; sck_err = 0; ld_err = 0; next_err = 0; idle_err = 0; sdi_err = 0;
    for (int k = 0; k < 1024; k++) begin
      @(negedge clk);
      exp_sck  = (k < 512) && (((k >> 3) & 1) == 1);
      exp_ld   = (k >= 520) && (k < 536);
      exp_next = (k == 0);
      if (sck !== exp_sck) sck_err++;
      if (ld !== exp_ld) ld_err++;
      if (next !== exp_next) next_err++;
      if (k >= 512 && (sck !== 1'b0 || sdi !== 1'b0)) idle_err++;
      if (k < 512 && sdi !== exp_word[31 - k/16]) sdi_err++;
      if (sck === 1'b1 && prev_sck === 1'b0) begin
        rises++;
        word = {word[30:0], sdi};
        if (ld === 1'b1) rises_in_ld++;
      end
      prev_sck = sck;
      if (k == chg_k) begin
        sample_l = nl;
        sample_r = nr;
      end
    end
    vectors++; if (word !== exp_word) begin miscompares++; $display("FAIL %s sdi_word: got %h want %h", name, word, exp_word); end
    vectors++; if (rises !== 32) begin miscompares++; $display("FAIL %s sck_rises: got %0d want 32", name, rises); end
    vectors++; if (rises_in_ld !== 0) begin miscompares++; $display("FAIL %s sck_rise_during_ld: got %0d want 0", name, rises_in_ld); end
    vectors++; if (sck_err !== 0) begin miscompares++; $display("FAIL %s sck_pattern: got %0d bad cycles want 0", name, sck_err); end
    vectors++; if (ld_err !== 0) begin miscompares++; $display("FAIL %s ld_window: got %0d bad cycles want 0", name, ld_err); end
    vectors++; if (next_err !== 0) begin miscompares++; $display("FAIL %s next_pulse: got %0d bad cycles want 0", name, next_err); end
    vectors++; if (idle_err !== 0) begin miscompares++; $display("FAIL %s idle_quiet: got %0d bad cycles want 0", name, idle_err); end
    vectors++; if (sdi_err !== 0) begin miscompares++; $display("FAIL %s sdi_per_cycle: got %0d bad cycles want 0", name, sdi_err); end
  endtask

  task automatic check_outputs_zero(input string name);
    vectors++; if (sck !== 1'b0) begin miscompares++; $display("FAIL %s sck: got %b want 0", name, sck); end
    vectors++; if (sdi !== 1'b0) begin miscompares++; $display("FAIL %s sdi: got %b want 0", name, sdi); end
    vectors++; if (ld !== 1'b0) begin miscompares++; $display("FAIL %s ld: got %b want 0", name, ld); end
    vectors++; if (next !== 1'b0) begin miscompares++; $display("FAIL %s next: got %b want 0", name, next); end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    check_outputs_zero("reset");
    reset = 1'b0;
  endtask

  task automatic test_first_frame();
    check_frame("first_frame", 32'h0FF0AA55 ^ (dac_word(16'h0, 16'h0)), 0, 16'h1234, 16'hAA55);
  endtask

  task automatic test_sample_change();
    check_frame("sample_change", dac_word(16'h1234, 16'hAA55), 300, 16'hDEAD, 16'hBEEF);
  endtask

  task automatic test_back_to_back();
    check_frame("back_to_back", dac_word(16'hDEAD, 16'hBEEF), 0, 16'h8000, 16'h7FFF);
  endtask

  task automatic test_signed();
`ifdef DAC_CTRL_SIGNED_EN
    check_frame("signed", 32'h0000FFFF, 0, 16'h0FF0, 16'hAA55);
`else
    check_frame("signed", 32'h80007FFF, 0, 16'h0FF0, 16'hAA55);
`endif
  endtask

  task automatic test_mid_reset();
    logic [31:0] w;
    w = dac_word(16'h0FF0, 16'hAA55);
    for (int k = 0; k <= 300; k++) @(negedge clk);
    // cnt=300 lies in the high half of bit 18, so sck and sdi are both driven high here.
    vectors++; if (sck !== 1'b1) begin miscompares++; $display("FAIL mid_reset_pre sck: got %b want 1", sck); end
    vectors++; if (sdi !== w[13]) begin miscompares++; $display("FAIL mid_reset_pre sdi: got %b want %b", sdi, w[13]); end
    #2 reset = 1'b1;
    #1 check_outputs_zero("mid_reset_async");
    repeat (3) @(negedge clk);
    check_outputs_zero("mid_reset_held");
    reset = 1'b0;
    check_frame("restart", w, -1, 16'h0FF0, 16'hAA55);
  endtask

  initial begin
    test_reset();
    test_first_frame();
    test_sample_change();
    test_back_to_back();
    test_signed();
    test_mid_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
